// File: rtl/id_exe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_exe_stage_reg_if
//  Description : Bus bundle between the decode stage and the ID/EX pipeline
//                register. Carries decoded control, datapath operands, the
//                pipe control requests and the registered/branch outputs.
//                Optional macro ID_EXE_PERF_EN adds the perf counter outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_exe_stage_reg_if;
    // decode controller
    logic [3:0]  exe_cmd_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        writeback_en_i;
    logic        is_immediate_i;
    logic [1:0]  branch_type_i;
    // datapath
    logic [31:0] pc_i;
    logic [31:0] val1_i;
    logic [31:0] val2_i;
    logic [15:0] imm_i;
    logic [4:0]  src1_i;
    logic [4:0]  src2_i;
    logic [4:0]  dest_i;
    // pipe control
    logic        hold_i;
    logic        flush_i;
    logic        hazard_i;
    // registered outputs
    logic [3:0]  exe_cmd_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        writeback_en_o;
    logic        is_immediate_o;
    logic [1:0]  branch_type_o;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] val1_o;
    logic [31:0] val2_o;
    logic [31:0] imm_o;
    logic [4:0]  src1_o;
    logic [4:0]  src2_o;
    logic [4:0]  dest_o;
    // branch resolution
    logic        br_taken_o;
    logic [31:0] br_target_o;
`ifdef ID_EXE_PERF_EN
    logic [15:0] bubble_cnt_o;
    logic [31:0] instr_cnt_o;
`endif

    // Decode side: drives the *_i fields, observes the stage outputs.
    modport master (
        output exe_cmd_i, mem_read_i, mem_write_i, writeback_en_i,
               is_immediate_i, branch_type_i, pc_i, val1_i, val2_i, imm_i,
               src1_i, src2_i, dest_i, hold_i, flush_i, hazard_i,
        input  exe_cmd_o, mem_read_o, mem_write_o, writeback_en_o,
               is_immediate_o, branch_type_o, valid_o, pc_o, val1_o, val2_o,
               imm_o, src1_o, src2_o, dest_o, br_taken_o, br_target_o
`ifdef ID_EXE_PERF_EN
        , input bubble_cnt_o, instr_cnt_o
`endif
    );

    // Pipeline register side.
    modport slave (
        input  exe_cmd_i, mem_read_i, mem_write_i, writeback_en_i,
               is_immediate_i, branch_type_i, pc_i, val1_i, val2_i, imm_i,
               src1_i, src2_i, dest_i, hold_i, flush_i, hazard_i,
        output exe_cmd_o, mem_read_o, mem_write_o, writeback_en_o,
               is_immediate_o, branch_type_o, valid_o, pc_o, val1_o, val2_o,
               imm_o, src1_o, src2_o, dest_o, br_taken_o, br_target_o
`ifdef ID_EXE_PERF_EN
        , output bubble_cnt_o, instr_cnt_o
`endif
    );
endinterface

`default_nettype wire

// File: rtl/id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_exe_stage_reg
//  Description : ID/EX pipeline register. Per rising edge: hold keeps state,
//                flush/hazard loads a bubble, otherwise the decoded
//                instruction is captured (immediate sign-extended). Branch
//                condition and target are resolved combinationally from the
//                registered fields. br_taken_o is meant to be routed to the
//                upstream flush by the top level; this block never drives it.
//                Optional macro ID_EXE_PERF_EN adds bubble/instruction
//                counters (bubble_cnt_o, instr_cnt_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module id_exe_stage_reg (
    input  wire logic          clk,
    input  wire logic          rst_n,
    id_exe_stage_reg_if.slave  bus
);

    localparam logic [1:0] c_BR_NONE = 2'b00;
    localparam logic [1:0] c_BR_BEZ  = 2'b01;
    localparam logic [1:0] c_BR_BNE  = 2'b10;
    localparam logic [1:0] c_BR_JMP  = 2'b11;

    logic [3:0]  r_exe_cmd;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_writeback_en;
    logic        r_is_immediate;
    logic [1:0]  r_branch_type;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_val1;
    logic [31:0] r_val2;
    logic [31:0] r_imm;
    logic [4:0]  r_src1;
    logic [4:0]  r_src2;
    logic [4:0]  r_dest;

    logic        w_bubble;
    logic        w_load;
    logic        w_cond;

    // hold dominates; a bubble wins over a normal load
    assign w_bubble = ~bus.hold_i & (bus.flush_i | bus.hazard_i);
    assign w_load   = ~bus.hold_i & ~bus.flush_i & ~bus.hazard_i;

    // Pipeline register: bubble clears every field, load captures the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exe_cmd      <= 4'd0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_writeback_en <= 1'b0;
            r_is_immediate <= 1'b0;
            r_branch_type  <= c_BR_NONE;
            r_valid        <= 1'b0;
            r_pc           <= 32'd0;
            r_val1         <= 32'd0;
            r_val2         <= 32'd0;
            r_imm          <= 32'd0;
            r_src1         <= 5'd0;
            r_src2         <= 5'd0;
            r_dest         <= 5'd0;
        end else if (w_bubble) begin
            r_exe_cmd      <= 4'd0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_writeback_en <= 1'b0;
            r_is_immediate <= 1'b0;
            r_branch_type  <= c_BR_NONE;
            r_valid        <= 1'b0;
            r_pc           <= 32'd0;
            r_val1         <= 32'd0;
            r_val2         <= 32'd0;
            r_imm          <= 32'd0;
            r_src1         <= 5'd0;
            r_src2         <= 5'd0;
            r_dest         <= 5'd0;
        end else if (w_load) begin
            r_exe_cmd      <= bus.exe_cmd_i;
            r_mem_read     <= bus.mem_read_i;
            r_mem_write    <= bus.mem_write_i;
            r_writeback_en <= bus.writeback_en_i;
            r_is_immediate <= bus.is_immediate_i;
            r_branch_type  <= bus.branch_type_i;
            r_valid        <= 1'b1;
            r_pc           <= bus.pc_i;
            r_val1         <= bus.val1_i;
            r_val2         <= bus.val2_i;
            r_imm          <= {{16{bus.imm_i[15]}}, bus.imm_i};
            r_src1         <= bus.src1_i;
            r_src2         <= bus.src2_i;
            r_dest         <= bus.dest_i;
        end
    end

    // Branch condition from the registered type; qualified by valid below.
    always_comb begin
        w_cond = 1'b0;
        case (r_branch_type)
            c_BR_BEZ:  w_cond = (r_val1 == 32'd0);
            c_BR_BNE:  w_cond = (r_val1 != r_val2);
            c_BR_JMP:  w_cond = 1'b1;
            default:   w_cond = 1'b0;
        endcase
    end

    assign bus.exe_cmd_o      = r_exe_cmd;
    assign bus.mem_read_o     = r_mem_read;
    assign bus.mem_write_o    = r_mem_write;
    assign bus.writeback_en_o = r_writeback_en;
    assign bus.is_immediate_o = r_is_immediate;
    assign bus.branch_type_o  = r_branch_type;
    assign bus.valid_o        = r_valid;
    assign bus.pc_o           = r_pc;
    assign bus.val1_o         = r_val1;
    assign bus.val2_o         = r_val2;
    assign bus.imm_o          = r_imm;
    assign bus.src1_o         = r_src1;
    assign bus.src2_o         = r_src2;
    assign bus.dest_o         = r_dest;
    // stale fields never leak: taken requires a valid instruction
    assign bus.br_taken_o     = r_valid & w_cond;
    // both operands are zero during reset, so the target is zero too
    assign bus.br_target_o    = r_pc + r_imm;

`ifdef ID_EXE_PERF_EN
    logic [15:0] r_bubble_cnt;
    logic [31:0] r_instr_cnt;

    // Perf counters: bubbles saturate, instructions wrap; hold freezes both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= 16'd0;
            r_instr_cnt  <= 32'd0;
        end else begin
            if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
            if (w_load) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign bus.bubble_cnt_o = r_bubble_cnt;
    assign bus.instr_cnt_o  = r_instr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_exe_stage_reg
//  Description : Self-checking bench for id_exe_stage_reg: vector table with
//                expected outputs queued at drive time and checked after the
//                edge, plus hand sequences for async reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_exe_stage_reg;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    id_exe_stage_reg_if ifc ();

    id_exe_stage_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hold, flush, hazard;
        logic [3:0]  cmd;
        logic        mr, mw, wb;
        logic [1:0]  bt;
        logic [31:0] pc, v1, v2;
        logic [15:0] imm;
        logic [4:0]  d;
        logic        e_valid;
        logic [3:0]  e_cmd;
        logic        e_wb, e_mr, e_mw;
        logic [4:0]  e_d;
        logic [31:0] e_imm, e_v1;
        logic        e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[12];
    vec_t sb_q[$];

    function automatic vec_t mk(
        input logic h, input logic f, input logic hz, input logic [3:0] cmd,
        input logic mr, input logic mw, input logic wb, input logic [1:0] bt,
        input logic [31:0] pc, input logic [31:0] v1, input logic [31:0] v2,
        input logic [15:0] imm, input logic [4:0] d,
        input logic ev, input logic [3:0] ecmd, input logic ewb, input logic emr,
        input logic emw, input logic [4:0] ed, input logic [31:0] eimm,
        input logic [31:0] ev1, input logic etk, input logic [31:0] etgt);
        vec_t r;
        r.hold = h; r.flush = f; r.hazard = hz; r.cmd = cmd;
        r.mr = mr; r.mw = mw; r.wb = wb; r.bt = bt;
        r.pc = pc; r.v1 = v1; r.v2 = v2; r.imm = imm; r.d = d;
        r.e_valid = ev; r.e_cmd = ecmd; r.e_wb = ewb; r.e_mr = emr;
        r.e_mw = emw; r.e_d = ed; r.e_imm = eimm; r.e_v1 = ev1;
        r.e_tk = etk; r.e_tgt = etgt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ifc.hold_i         = v.hold;
        ifc.flush_i        = v.flush;
        ifc.hazard_i       = v.hazard;
        ifc.exe_cmd_i      = v.cmd;
        ifc.mem_read_i     = v.mr;
        ifc.mem_write_i    = v.mw;
        ifc.writeback_en_i = v.wb;
        ifc.is_immediate_i = 1'b0;
        ifc.branch_type_i  = v.bt;
        ifc.pc_i           = v.pc;
        ifc.val1_i         = v.v1;
        ifc.val2_i         = v.v2;
        ifc.imm_i          = v.imm;
        ifc.src1_i         = 5'd1;
        ifc.src2_i         = 5'd2;
        ifc.dest_i         = v.d;
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        check({tag, ".valid"},  {31'd0, ifc.valid_o},        {31'd0, e.e_valid});
        check({tag, ".cmd"},    {28'd0, ifc.exe_cmd_o},      {28'd0, e.e_cmd});
        check({tag, ".wb"},     {31'd0, ifc.writeback_en_o}, {31'd0, e.e_wb});
        check({tag, ".mr"},     {31'd0, ifc.mem_read_o},     {31'd0, e.e_mr});
        check({tag, ".mw"},     {31'd0, ifc.mem_write_o},    {31'd0, e.e_mw});
        check({tag, ".dest"},   {27'd0, ifc.dest_o},         {27'd0, e.e_d});
        check({tag, ".imm"},    ifc.imm_o,                   e.e_imm);
        check({tag, ".val1"},   ifc.val1_o,                  e.e_v1);
        check({tag, ".taken"},  {31'd0, ifc.br_taken_o},     {31'd0, e.e_tk});
        check({tag, ".target"}, ifc.br_target_o,             e.e_tgt);
    endtask

    vec_t cur;
    vec_t exp_v;
    vec_t zero_v;

    initial begin
        total = 0;
        bad   = 0;
        //               h  f  hz cmd   mr mw wb bt     pc            v1          v2     imm       d       ev ecmd  ewb emr emw ed     eimm          ev1          etk etgt
        vecs[0]  = mk(0, 0, 0, 4'd0, 0, 0, 1, 2'b00, 32'h4,        32'd5,      32'd7, 16'h0000, 5'd3,  1, 4'd0, 1, 0, 0, 5'd3,  32'h0,        32'd5,       0, 32'h4);
        vecs[1]  = mk(0, 0, 0, 4'd2, 0, 0, 0, 2'b10, 32'h10,       32'd1,      32'd2, 16'hFFFE, 5'd0,  1, 4'd2, 0, 0, 0, 5'd0,  32'hFFFFFFFE, 32'd1,       1, 32'h0E);
        vecs[2]  = mk(0, 0, 0, 4'd5, 0, 1, 0, 2'b00, 32'h20,       32'd8,      32'd9, 16'h0004, 5'd0,  1, 4'd5, 0, 0, 1, 5'd0,  32'h4,        32'd8,       0, 32'h24);
        vecs[3]  = mk(1, 1, 0, 4'd0, 0, 0, 1, 2'b11, 32'h60,       32'd99,     32'd1, 16'h0001, 5'd7,  1, 4'd5, 0, 0, 1, 5'd0,  32'h4,        32'd8,       0, 32'h24);
        vecs[4]  = mk(0, 1, 0, 4'd0, 0, 0, 1, 2'b11, 32'h60,       32'd99,     32'd1, 16'h0001, 5'd7,  0, 4'd0, 0, 0, 0, 5'd0,  32'h0,        32'd0,       0, 32'h0);
        vecs[5]  = mk(0, 0, 1, 4'd4, 1, 0, 1, 2'b00, 32'h30,       32'd100,    32'd0, 16'h0008, 5'd5,  0, 4'd0, 0, 0, 0, 5'd0,  32'h0,        32'd0,       0, 32'h0);
        vecs[6]  = mk(0, 0, 0, 4'd1, 0, 0, 0, 2'b01, 32'h40,       32'd0,      32'd3, 16'h0010, 5'd0,  1, 4'd1, 0, 0, 0, 5'd0,  32'h10,       32'd0,       1, 32'h50);
        vecs[7]  = mk(0, 0, 0, 4'd1, 0, 0, 0, 2'b01, 32'h44,       32'd1,      32'd3, 16'h0008, 5'd0,  1, 4'd1, 0, 0, 0, 5'd0,  32'h8,        32'd1,       0, 32'h4C);
        vecs[8]  = mk(0, 0, 0, 4'd3, 0, 0, 0, 2'b11, 32'hFFFFFFF0, 32'd7,      32'd7, 16'h0020, 5'd0,  1, 4'd3, 0, 0, 0, 5'd0,  32'h20,       32'd7,       1, 32'h10);
        vecs[9]  = mk(0, 0, 0, 4'd2, 0, 0, 0, 2'b10, 32'h0,        32'd6,      32'd6, 16'h7FFF, 5'd0,  1, 4'd2, 0, 0, 0, 5'd0,  32'h7FFF,     32'd6,       0, 32'h7FFF);
        vecs[10] = mk(1, 0, 1, 4'd9, 1, 1, 1, 2'b11, 32'h1,        32'd0,      32'd0, 16'h1111, 5'd9,  1, 4'd2, 0, 0, 0, 5'd0,  32'h7FFF,     32'd6,       0, 32'h7FFF);
        vecs[11] = mk(0, 0, 0, 4'd4, 1, 0, 1, 2'b00, 32'h100,      32'h1234,   32'd0, 16'h8000, 5'd31, 1, 4'd4, 1, 1, 0, 5'd31, 32'hFFFF8000, 32'h1234,    0, 32'hFFFF8100);
        zero_v   = mk(0, 0, 0, 4'd0, 0, 0, 0, 2'b00, 32'h0,        32'd0,      32'd0, 16'h0000, 5'd0,  0, 4'd0, 0, 0, 0, 5'd0,  32'h0,        32'd0,       0, 32'h0);

        // reset state, before any clock edge
        rst_n = 1'b0;
        drive(vecs[0]);
        #2;
        check_vec("reset", zero_v);
        @(negedge clk);
        rst_n = 1'b1;

        // table: push expectation at drive, pop and compare after the edge
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            sb_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                exp_v = sb_q.pop_front();
                check_vec($sformatf("vec%0d", i), exp_v);
            end
            @(negedge clk);
        end

        // async reset mid-cycle while a valid instruction is registered
        check("pre_reset.valid", {31'd0, ifc.valid_o}, 32'd1);
        cur = vecs[2];
        cur.hold = 1'b1;
        cur.flush = 1'b1;
        drive(cur);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_rst", zero_v);
        check("async_rst.pc", ifc.pc_o, 32'd0);
        @(posedge clk);
        #1;
        check_vec("rst_held", zero_v);
        @(negedge clk);
        rst_n = 1'b1;
        // first edge after release with hold: stays empty
        @(posedge clk);
        #1;
        check_vec("post_rst_hold", zero_v);
        @(negedge clk);
        drive(vecs[0]);
        sb_q.push_back(vecs[0]);
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        check_vec("post_rst_load", exp_v);

`ifdef ID_EXE_PERF_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(vecs[0]);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            drive(vecs[4]);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            drive(vecs[3]);
            @(negedge clk);
        end
        check("perf.instr",  ifc.instr_cnt_o, 32'd3);
        check("perf.bubble", {16'd0, ifc.bubble_cnt_o}, 32'd2);
        drive(vecs[4]);
        repeat (65533) @(negedge clk);
        check("perf.bubble_max", {16'd0, ifc.bubble_cnt_o}, 32'h0000FFFF);
        @(negedge clk);
        check("perf.bubble_sat", {16'd0, ifc.bubble_cnt_o}, 32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_exe_stage_reg.md
ID_EXE_STAGE_REG -- requirements
Module: id_exe_stage_reg

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, the only clock.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have inputs from the decode controller: exe_cmd_i 4, mem_read_i 1, mem_write_i 1, writeback_en_i 1, is_immediate_i 1, branch_type_i 2 (00 none, 01 BEZ, 10 BNE, 11 JMP).
REQ-004 SHALL have datapath inputs: pc_i 32 (address of next instruction), val1_i 32, val2_i 32 (register-file reads), imm_i 16 (raw immediate), src1_i 5, src2_i 5, dest_i 5.
REQ-005 SHALL have control inputs: hold_i 1 (freeze whole pipe), flush_i 1 (squash, taken branch), hazard_i 1 (load-use bubble request).
REQ-006 SHALL have registered outputs: exe_cmd_o 4, mem_read_o, mem_write_o, writeback_en_o, is_immediate_o, branch_type_o 2, valid_o 1, pc_o 32, val1_o 32, val2_o 32, imm_o 32, src1_o 5, src2_o 5, dest_o 5.
REQ-007 SHALL have combinational outputs: br_taken_o 1, br_target_o 32.

Function
REQ-008 SHALL update state only on rising clk; action per edge decided by priority hold_i > (flush_i | hazard_i) > load.
REQ-009 hold_i=1: SHALL keep every register unchanged, regardless of flush_i/hazard_i.
REQ-010 hold_i=0 and (flush_i=1 or hazard_i=1): SHALL load a bubble: valid_o=0, writeback_en_o=0, mem_read_o=0, mem_write_o=0, branch_type_o=00, exe_cmd_o=0, is_immediate_o=0, dest_o=0; datapath fields SHALL also be cleared to 0.
REQ-011 hold_i=0, flush_i=0, hazard_i=0: SHALL capture all *_i fields with valid_o=1; latency one cycle input to output.
REQ-012 imm_o SHALL be imm_i sign-extended from bit 15 to 32 bits at capture.
REQ-013 br_taken_o SHALL be valid_o AND: branch_type_o=01 -> val1_o==0; 10 -> val1_o!=val2_o; 11 -> 1; 00 -> 0.
REQ-014 br_target_o SHALL be pc_o + imm_o, 32-bit modular (wrap-around, no overflow flag).
REQ-015 br_taken_o SHALL be 0 whenever valid_o=0, independent of stale fields.
REQ-016 The block SHALL NOT drive flush_i itself; the top level SHALL route br_taken_o to upstream flush.

Reset
REQ-017 rst_n=0 SHALL immediately, without clk, force every registered output to 0 (equivalent to a bubble, valid_o=0).
REQ-018 Reset asserted mid-hold or mid-flush SHALL override both; first edge after rst_n rises SHALL follow REQ-008.
REQ-019 br_taken_o SHALL be 0 and br_target_o 0 throughout reset.

Configuration
REQ-020 Macro ID_EXE_PERF_EN, when defined, SHALL add outputs bubble_cnt_o 16 and instr_cnt_o 32.
REQ-021 With ID_EXE_PERF_EN: bubble_cnt_o SHALL increment on each edge executing REQ-010, saturating at 16'hFFFF; instr_cnt_o SHALL increment on each edge executing REQ-011, wrapping at 2^32; neither changes during hold_i; both reset to 0 by rst_n.
REQ-022 Without ID_EXE_PERF_EN: those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-023 Load: opcode-ADD fields exe_cmd_i=0, writeback_en_i=1, val1_i=5, val2_i=7, dest_i=3 -> next cycle valid_o=1, writeback_en_o=1, dest_o=3, val1_o=5.
REQ-024 Sign extension/branch: BNE, imm_i=16'hFFFE, pc_i=32'h10, val1_i=1, val2_i=2 -> imm_o=32'hFFFFFFFE, br_taken_o=1, br_target_o=32'h0E.
REQ-025 Priority: hold_i=1 and flush_i=1 with loaded ST instruction -> outputs unchanged, mem_write_o stays 1; drop hold_i -> next edge bubble, mem_write_o=0, br_taken_o=0.
REQ-026 Hazard: hazard_i=1 with LD inputs -> valid_o=0, mem_read_o=0; BEZ with val1_i=0 next cycle -> br_taken_o=1.
REQ-027 Async reset: assert rst_n=0 between clk edges while valid_o=1 -> all outputs 0 before next edge.
REQ-028 Perf (ID_EXE_PERF_EN): 3 loads, 2 bubbles, 4 hold cycles -> instr_cnt_o=3, bubble_cnt_o=2; preload 16'hFFFF then bubble -> stays 16'hFFFF.
